// File: rtl/rstmgr_multi_if.sv
// Handshake bundle between the reset manager and the SoC.
// The master side drives the reset sources and consumes the resets and reset cause.
// The slave side is the reset manager itself.
interface rstmgr_multi_if #(
    parameter int NumDomains = 4
) ();
    logic                  prog_rst_ni;
    logic                  ndmreset_i;
    logic [NumDomains-1:0] sw_rst_req_i;
    logic                  cause_clr_i;
    logic [NumDomains-1:0] rst_no;
    logic [3:0]            rst_cause_o;
    logic                  rst_done_o;

    modport master (
        output prog_rst_ni, ndmreset_i, sw_rst_req_i, cause_clr_i,
        input  rst_no, rst_cause_o, rst_done_o
    );

    modport slave (
        input  prog_rst_ni, ndmreset_i, sw_rst_req_i, cause_clr_i,
        output rst_no, rst_cause_o, rst_done_o
    );
endinterface

// File: rtl/rstmgr_multi.sv
// Multi-domain reset manager.
// Each domain gets an independent registered active-low reset. A domain's reset is
// built from a masked set of sources (POR/FSM state, programming, ndmreset, software)
// and is held low for HoldCycles extra cycles after its sources go quiet. A sticky
// cause register tells the SoC what caused the last reset(s).
module rstmgr_multi #(
    parameter int                    NumDomains = 4,
    parameter int                    HoldCycles = 8,
    parameter logic [NumDomains-1:0] ProgMask   = 4'b1110,
    parameter logic [NumDomains-1:0] NdmMask    = 4'b1110,
    parameter logic [NumDomains-1:0] SwMask     = 4'b1111
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    rstmgr_multi_if.slave  bus
);

    // A hold of zero still needs a one-bit counter so the structure stays uniform.
    localparam int CntW = (HoldCycles < 1) ? 1 : $clog2(HoldCycles + 1);
    localparam logic [CntW-1:0] HoldVal = CntW'(HoldCycles);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    // Spare encoding 2'b11 is unreachable and is steered back to ST_RESET.
    typedef enum logic [1:0] {
        ST_RESET = 2'b00,
        ST_PROG  = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    state_e                r_state;
    logic [CntW-1:0]       r_cnt [NumDomains];
    logic [NumDomains-1:0] r_rst_no;
    logic [3:0]            r_cause;

    logic [NumDomains-1:0] w_src;
    logic [3:0]            w_cause_set;
    logic                  w_active;

    // Per-domain reset sources, each gated by its domain mask.
    always_comb begin
        w_src = '0;
        for (int i = 0; i < NumDomains; i++) begin
            w_src[i] = (r_state == ST_RESET)
                     | ((r_state == ST_PROG) & ProgMask[i])
                     | (bus.ndmreset_i & NdmMask[i])
                     | (bus.sw_rst_req_i[i] & SwMask[i]);
        end
    end

    // Cause bits that are set this cycle; POR is only ever set by the async reset.
    always_comb begin
        w_active       = (r_state == ST_RUN) | (r_state == ST_PROG);
        w_cause_set    = 4'b0000;
        w_cause_set[0] = 1'b0;
        w_cause_set[1] = (r_state == ST_RUN) & ~bus.prog_rst_ni;
        w_cause_set[2] = w_active & bus.ndmreset_i;
        w_cause_set[3] = w_active & (|(bus.sw_rst_req_i & SwMask));
    end

    // Top-level sequencing: one RESET cycle, then RUN or PROG following prog_rst_ni.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_RESET;
        end else begin
            case (r_state)
                ST_RESET: r_state <= bus.prog_rst_ni ? ST_RUN : ST_PROG;
                ST_RUN:   r_state <= bus.prog_rst_ni ? ST_RUN : ST_PROG;
                ST_PROG:  r_state <= bus.prog_rst_ni ? ST_RUN : ST_PROG;
                default:  r_state <= ST_RESET;
            endcase
        end
    end

    // Stretch counters and registered domain resets; a new source event reloads the stretch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rst_no <= '0;
            for (int i = 0; i < NumDomains; i++) begin
                r_cnt[i] <= HoldVal;
            end
        end else begin
            for (int i = 0; i < NumDomains; i++) begin
                if (w_src[i]) begin
                    r_cnt[i] <= HoldVal;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - CntOne;
                end else begin
                    r_cnt[i] <= r_cnt[i];
                end
                r_rst_no[i] <= ~(w_src[i] | (r_cnt[i] != '0));
            end
        end
    end

    // Sticky cause register; a bit being set in the same cycle beats the clear pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cause <= 4'b0001;
        end else if (bus.cause_clr_i) begin
            r_cause <= w_cause_set;
        end else begin
            r_cause <= r_cause | w_cause_set;
        end
    end

    assign bus.rst_no      = r_rst_no;
    assign bus.rst_cause_o = r_cause;
    assign bus.rst_done_o  = &r_rst_no;

endmodule

// File: tb/tb_rstmgr_multi.sv
// Directed bench for rstmgr_multi with the default 4-domain, 8-cycle-hold configuration.
module tb_rstmgr_multi;

    logic clk_i;
    logic rst_ni;
    int   n_cmp;
    int   n_err;

    rstmgr_multi_if #(.NumDomains(4)) bus ();

    rstmgr_multi #(
        .NumDomains (4),
        .HoldCycles (8),
        .ProgMask   (4'b1110),
        .NdmMask    (4'b1110),
        .SwMask     (4'b1111)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_ni = 1'b0;
        bus.prog_rst_ni  = 1'b1;
        bus.ndmreset_i   = 1'b0;
        bus.sw_rst_req_i = 4'b0000;
        bus.cause_clr_i  = 1'b0;

        // Reset state
        step();
        step();
        chk("por_rst_no", {28'd0, bus.rst_no}, 32'h0);
        chk("por_done", {31'd0, bus.rst_done_o}, 32'h0);
        chk("por_cause", {28'd0, bus.rst_cause_o}, 32'h1);

        // POR release: RESET->RUN edge plus 8 stretch edges low, released on the 10th edge
        rst_ni = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("por_hold", {28'd0, bus.rst_no}, 32'h0);
        end
        step();
        chk("por_release", {28'd0, bus.rst_no}, 32'hF);
        chk("por_rel_done", {31'd0, bus.rst_done_o}, 32'h1);
        chk("por_rel_cause", {28'd0, bus.rst_cause_o}, 32'h1);

        // Programming reset held for 20 cycles
        bus.prog_rst_ni = 1'b0;
        step();
        chk("prog_enter", {28'd0, bus.rst_no}, 32'hF);
        for (int k = 2; k <= 20; k++) begin
            step();
            chk("prog_hold", {28'd0, bus.rst_no}, 32'h1);
        end
        chk("prog_done", {31'd0, bus.rst_done_o}, 32'h0);
        bus.prog_rst_ni = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("prog_stretch", {28'd0, bus.rst_no}, 32'h1);
        end
        step();
        chk("prog_release", {28'd0, bus.rst_no}, 32'hF);
        chk("prog_cause", {28'd0, bus.rst_cause_o}, 32'h3);

        // Clear pulse with no simultaneous set
        bus.cause_clr_i = 1'b1;
        step();
        bus.cause_clr_i = 1'b0;
        chk("clr_cause", {28'd0, bus.rst_cause_o}, 32'h0);

        // ndmreset pulse: debug domain 0 untouched
        bus.ndmreset_i = 1'b1;
        step();
        bus.ndmreset_i = 1'b0;
        chk("ndm_assert", {28'd0, bus.rst_no}, 32'h1);
        chk("ndm_cause", {28'd0, bus.rst_cause_o}, 32'h4);
        for (int k = 2; k <= 9; k++) begin
            step();
            chk("ndm_hold", {28'd0, bus.rst_no}, 32'h1);
        end
        step();
        chk("ndm_release", {28'd0, bus.rst_no}, 32'hF);

        // Software request on domain 2, re-pulsed five cycles later
        bus.sw_rst_req_i = 4'b0100;
        step();
        bus.sw_rst_req_i = 4'b0000;
        chk("sw_assert", {28'd0, bus.rst_no}, 32'hB);
        chk("sw_cause", {28'd0, bus.rst_cause_o}, 32'hC);
        for (int k = 2; k <= 5; k++) begin
            step();
            chk("sw_hold1", {28'd0, bus.rst_no}, 32'hB);
        end
        bus.sw_rst_req_i = 4'b0100;
        step();
        bus.sw_rst_req_i = 4'b0000;
        chk("sw_repulse", {28'd0, bus.rst_no}, 32'hB);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("sw_hold2", {28'd0, bus.rst_no}, 32'hB);
        end
        step();
        chk("sw_release", {28'd0, bus.rst_no}, 32'hF);

        // Async POR in the middle of a programming stretch
        bus.prog_rst_ni = 1'b0;
        step();
        step();
        chk("async_prog", {28'd0, bus.rst_no}, 32'h1);
        bus.prog_rst_ni = 1'b1;
        step();
        step();
        step();
        chk("async_stretch", {28'd0, bus.rst_no}, 32'h1);
        #3;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_no", {28'd0, bus.rst_no}, 32'h0);
        chk("async_cause", {28'd0, bus.rst_cause_o}, 32'h1);
        chk("async_done", {31'd0, bus.rst_done_o}, 32'h0);
        step();
        rst_ni = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
        end
        chk("async_pre_rel", {28'd0, bus.rst_no}, 32'h0);
        step();
        chk("async_release", {28'd0, bus.rst_no}, 32'hF);

        // Clear with simultaneous software request on domain 1: SW bit survives
        bus.cause_clr_i  = 1'b1;
        bus.sw_rst_req_i = 4'b0010;
        step();
        bus.cause_clr_i  = 1'b0;
        bus.sw_rst_req_i = 4'b0000;
        chk("clr_sw_cause", {28'd0, bus.rst_cause_o}, 32'h8);
        chk("clr_sw_rst_no", {28'd0, bus.rst_no}, 32'hD);
        chk("clr_sw_done", {31'd0, bus.rst_done_o}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
